// File: rtl/dmem_lsu_if.sv
// Request/response bus between a load-store client and the dmem_lsu data memory.
// One request is outstanding at a time; both channels use valid/ready handshakes.
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with RISC-V style sized loads/stores, a fixed
// response latency and a post-reset fill pattern (byte n holds n mod 256).
module dmem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 1,
  parameter bit INIT_EN     = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  dmem_lsu_if.slave bus,
  output logic     init_done
);

  localparam int IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int BYTE_W   = IDX_W + 2;
  localparam int BUSY_CYC = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [ADDR_W:0] BYTE_CAP = (ADDR_W + 1)'(4 * DEPTH_WORDS);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_RESP} state_t;

  state_t           state;
  logic [IDX_W-1:0] fill_cnt;
  logic [1:0]       busy_cnt;
  logic             ready_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_rdata_q;
  logic             rsp_err_q;
  logic [31:0]      held_rdata;
  logic             held_err;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [BYTE_W-1:0] baddr;
  logic [IDX_W-1:0]  widx;
  logic [1:0]        off;
  logic              accept;
  logic              fault;
  logic [31:0]       rd_word;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_data;
  logic [31:0]       rsp_next;
  logic [3:0]        st_be;
  logic [31:0]       st_data;
  logic [7:0]        fill_base;
  logic [31:0]       fill_word;

  // Range check runs on the full address first, so the truncated index never aliases.
  assign baddr  = bus.req_addr[BYTE_W-1:0];
  assign widx   = baddr[BYTE_W-1:2];
  assign off    = baddr[1:0];
  assign accept = (state == S_IDLE) && bus.req_valid;

  assign fill_base = 8'({fill_cnt, 2'b00});
  assign fill_word = {fill_base + 8'd3, fill_base + 8'd2, fill_base + 8'd1, fill_base};

  assign rd_word  = mem[widx];
  assign rd_shift = rd_word >> {off, 3'b000};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fault   = ({1'b0, bus.req_addr} >= BYTE_CAP);
    ld_data = rd_word;
    st_be   = 4'b0000;
    st_data = bus.req_wdata;
    case (bus.req_funct3)
      F_B: begin
        ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
        st_be   = 4'b0001 << off;
        st_data = {4{bus.req_wdata[7:0]}};
      end
      F_BU: begin
        fault   = fault | bus.req_we;
        ld_data = {24'd0, rd_shift[7:0]};
      end
      F_H: begin
        fault   = fault | baddr[0];
        ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
        st_be   = 4'b0011 << off;
        st_data = {2{bus.req_wdata[15:0]}};
      end
      F_HU: begin
        fault   = fault | baddr[0] | bus.req_we;
        ld_data = {16'd0, rd_shift[15:0]};
      end
      F_W: begin
        fault   = fault | (off != 2'b00);
        st_be   = 4'b1111;
      end
      default: fault = 1'b1;
    endcase
    rsp_next = (fault || bus.req_we) ? 32'd0 : ld_data;
  end

  // NOTE: the memory array has no reset; INIT rewrites it after every reset release.
  always_ff @(posedge clk) begin
    if (INIT_EN && state == S_INIT) begin
      mem[fill_cnt] <= fill_word;
    end else if (accept && bus.req_we && !fault) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_INIT;
      fill_cnt    <= '0;
      busy_cnt    <= 2'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      held_rdata  <= 32'd0;
      held_err    <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (!INIT_EN || fill_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
            state     <= S_IDLE;
            ready_q   <= 1'b1;
            init_done <= 1'b1;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        S_IDLE: begin
          if (bus.req_valid) begin
            ready_q    <= 1'b0;
            held_rdata <= rsp_next;
            held_err   <= fault;
            if (LATENCY <= 1) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_next;
              rsp_err_q   <= fault;
            end else begin
              state    <= S_BUSY;
              busy_cnt <= 2'(BUSY_CYC);
            end
          end
        end
        S_BUSY: begin
          if (busy_cnt == 2'd0) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= held_rdata;
            rsp_err_q   <= held_err;
          end else begin
            busy_cnt <= busy_cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state       <= S_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
